// File: rtl/lu_entry_composer.sv
// Packs per-packet L2 and ARP/IPv4 parser results into one flow lookup key
// and offers it to the flow-table lookup stage over a req/ack handshake.
module lu_entry_composer #(
  parameter int unsigned C_AXIS_LEN_DATA_WIDTH = 16,
  parameter int unsigned C_AXIS_SPT_DATA_WIDTH = 8,
  parameter int unsigned C_L3_TIMEOUT          = 64,
  localparam int unsigned C_KEY_WIDTH          = C_AXIS_SPT_DATA_WIDTH + 206
) (
  input  logic                             asclk,
  input  logic                             aresetn,
  input  logic                             dl_start,
  input  logic                             dl_done,
  input  logic [C_AXIS_LEN_DATA_WIDTH-1:0] pkt_len,
  input  logic [C_AXIS_SPT_DATA_WIDTH-1:0] src_port,
  input  logic [47:0]                      dl_dst,
  input  logic [47:0]                      dl_src,
  input  logic [15:0]                      dl_ethtype,
  input  logic [15:0]                      dl_vlantag,
  input  logic                             arp_done,
  input  logic [7:0]                       arp_op,
  input  logic [31:0]                      arp_ip_src,
  input  logic [31:0]                      arp_ip_dst,
  input  logic                             ip_tp_done,
  input  logic [5:0]                       ip_tos,
  input  logic [7:0]                       ip_proto,
  input  logic [31:0]                      ip_src,
  input  logic [31:0]                      ip_dst,
  output logic                             compose_done,
  output logic [C_KEY_WIDTH-1:0]           lu_entry,
  output logic [C_AXIS_LEN_DATA_WIDTH-1:0] lu_pkt_len,
  output logic                             lu_req,
  input  logic                             lu_ack,
  output logic [31:0]                      compose_cnt,
  output logic [31:0]                      timeout_cnt,
  output logic [31:0]                      drop_cnt
);

  localparam int unsigned CNT_W = $clog2(C_L3_TIMEOUT + 1);
  localparam logic [15:0] ETH_IPV4 = 16'h0800;
  localparam logic [15:0] ETH_ARP  = 16'h0806;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_L3, S_OUTPUT} state_t;

  state_t r_state, w_state_nxt;

  logic [C_AXIS_SPT_DATA_WIDTH-1:0] r_src_port;
  logic [C_AXIS_LEN_DATA_WIDTH-1:0] r_pkt_len;
  logic [47:0]      r_dl_dst, r_dl_src;
  logic [15:0]      r_ethtype, r_vlantag;
  logic [5:0]       r_tos;
  logic [7:0]       r_proto;
  logic [31:0]      r_l3_src, r_l3_dst;
  logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic             r_lu_req, r_compose_done;
  logic [31:0]      r_compose_cnt, r_timeout_cnt, r_drop_cnt;

  logic w_clear_all, w_latch_l2, w_zero_l3, w_latch_ip, w_latch_arp;
  logic w_drop, w_timeout, w_accept, w_wait_arp, w_exp_done, w_unexp_done;

  assign w_wait_arp   = (r_ethtype == ETH_ARP);
  assign w_exp_done   = w_wait_arp ? arp_done : ip_tp_done;
  assign w_unexp_done = w_wait_arp ? ip_tp_done : arp_done;

  always_ff @(posedge asclk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state plus datapath control strobes.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_clear_all    = 1'b0;
    w_latch_l2     = 1'b0;
    w_zero_l3      = 1'b0;
    w_latch_ip     = 1'b0;
    w_latch_arp    = 1'b0;
    w_drop         = 1'b0;
    w_timeout      = 1'b0;
    w_accept       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clear_all = dl_start;
        if (dl_done) begin
          w_latch_l2 = 1'b1;
          w_zero_l3  = 1'b1;
          // Wait counter counts cycles since dl_done; the dl_done cycle is 0.
          w_wait_cnt_nxt = CNT_W'(1);
          if (dl_ethtype == ETH_IPV4) begin
            w_latch_ip  = ip_tp_done;
            w_state_nxt = ip_tp_done ? S_OUTPUT : S_WAIT_L3;
          end else if (dl_ethtype == ETH_ARP) begin
            w_latch_arp = arp_done;
            w_state_nxt = arp_done ? S_OUTPUT : S_WAIT_L3;
          end else begin
            w_state_nxt = S_OUTPUT;
          end
        end else begin
          w_drop = arp_done | ip_tp_done;
        end
      end
      S_WAIT_L3: begin
        w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        w_drop         = w_unexp_done | dl_done | dl_start;
        if (w_exp_done) begin
          w_latch_ip  = ~w_wait_arp;
          w_latch_arp = w_wait_arp;
          w_state_nxt = S_OUTPUT;
        end else if (r_wait_cnt == CNT_W'(C_L3_TIMEOUT - 1)) begin
          w_zero_l3   = 1'b1;
          w_timeout   = 1'b1;
          w_state_nxt = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        w_drop = dl_done | dl_start | arp_done | ip_tp_done;
        if (lu_ack) begin
          w_accept    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latched key fields; later assignments take priority within a cycle.
  always_ff @(posedge asclk or negedge aresetn) begin
    if (!aresetn) begin
      r_src_port <= '0;
      r_pkt_len  <= '0;
      r_dl_dst   <= '0;
      r_dl_src   <= '0;
      r_ethtype  <= '0;
      r_vlantag  <= '0;
      r_tos      <= '0;
      r_proto    <= '0;
      r_l3_src   <= '0;
      r_l3_dst   <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_clear_all) begin
        r_src_port <= '0;
        r_pkt_len  <= '0;
        r_dl_dst   <= '0;
        r_dl_src   <= '0;
        r_ethtype  <= '0;
        r_vlantag  <= '0;
      end
      if (w_clear_all || w_zero_l3) begin
        r_tos    <= '0;
        r_proto  <= '0;
        r_l3_src <= '0;
        r_l3_dst <= '0;
      end
      if (w_latch_l2) begin
        r_src_port <= src_port;
        r_pkt_len  <= pkt_len;
        r_dl_dst   <= dl_dst;
        r_dl_src   <= dl_src;
        r_ethtype  <= dl_ethtype;
        r_vlantag  <= dl_vlantag;
      end
      if (w_latch_ip) begin
        r_tos    <= ip_tos;
        r_proto  <= ip_proto;
        r_l3_src <= ip_src;
        r_l3_dst <= ip_dst;
      end
      if (w_latch_arp) begin
        r_tos    <= '0;
        r_proto  <= arp_op;
        r_l3_src <= arp_ip_src;
        r_l3_dst <= arp_ip_dst;
      end
    end
  end

  // Handshake outputs and statistics.
  always_ff @(posedge asclk or negedge aresetn) begin
    if (!aresetn) begin
      r_lu_req       <= 1'b0;
      r_compose_done <= 1'b0;
      r_compose_cnt  <= '0;
      r_timeout_cnt  <= '0;
      r_drop_cnt     <= '0;
    end else begin
      r_lu_req       <= (w_state_nxt == S_OUTPUT);
      r_compose_done <= w_accept;
      if (w_accept)  r_compose_cnt <= r_compose_cnt + 32'd1;
      if (w_timeout) r_timeout_cnt <= r_timeout_cnt + 32'd1;
      if (w_drop)    r_drop_cnt    <= r_drop_cnt + 32'd1;
    end
  end

  assign lu_entry     = {r_src_port, r_dl_src, r_dl_dst, r_vlantag, r_ethtype,
                         r_tos, r_proto, r_l3_src, r_l3_dst};
  assign lu_pkt_len   = r_pkt_len;
  assign lu_req       = r_lu_req;
  assign compose_done = r_compose_done;
  assign compose_cnt  = r_compose_cnt;
  assign timeout_cnt  = r_timeout_cnt;
  assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_lu_entry_composer.sv
// Bench for lu_entry_composer: directed and randomized packets scored against a
// packet-level model of key contents, request latency and statistics.
module tb_lu_entry_composer;

  localparam int T  = 64;
  localparam int KW = 214;

  logic          asclk = 1'b0;
  logic          aresetn;
  logic          dl_start, dl_done, arp_done, ip_tp_done, lu_ack;
  logic [15:0]   pkt_len, dl_ethtype, dl_vlantag;
  logic [7:0]    src_port, arp_op, ip_proto;
  logic [47:0]   dl_dst, dl_src;
  logic [31:0]   arp_ip_src, arp_ip_dst, ip_src, ip_dst;
  logic [5:0]    ip_tos;
  logic          compose_done, lu_req;
  logic [KW-1:0] lu_entry;
  logic [15:0]   lu_pkt_len;
  logic [31:0]   compose_cnt, timeout_cnt, drop_cnt;

  lu_entry_composer dut (
    .asclk(asclk), .aresetn(aresetn), .dl_start(dl_start), .dl_done(dl_done),
    .pkt_len(pkt_len), .src_port(src_port), .dl_dst(dl_dst), .dl_src(dl_src),
    .dl_ethtype(dl_ethtype), .dl_vlantag(dl_vlantag), .arp_done(arp_done),
    .arp_op(arp_op), .arp_ip_src(arp_ip_src), .arp_ip_dst(arp_ip_dst),
    .ip_tp_done(ip_tp_done), .ip_tos(ip_tos), .ip_proto(ip_proto),
    .ip_src(ip_src), .ip_dst(ip_dst), .compose_done(compose_done),
    .lu_entry(lu_entry), .lu_pkt_len(lu_pkt_len), .lu_req(lu_req),
    .lu_ack(lu_ack), .compose_cnt(compose_cnt), .timeout_cnt(timeout_cnt),
    .drop_cnt(drop_cnt)
  );

  always #5 asclk = ~asclk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_compose = 0, exp_timeout = 0, exp_drop = 0;

  // Fields of the packet currently being offered.
  logic [7:0]  f_src_port, f_proto, f_arp_op;
  logic [47:0] f_dl_dst, f_dl_src;
  logic [15:0] f_eth, f_vlan, f_len;
  logic [5:0]  f_tos;
  logic [31:0] f_l3src, f_l3dst;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge asclk);
    #1;
  endtask

  // Random values on every data bus, all strobes low.
  task automatic noise();
    dl_start = 1'b0; dl_done = 1'b0; arp_done = 1'b0; ip_tp_done = 1'b0;
    pkt_len = 16'($urandom); src_port = 8'($urandom);
    dl_dst = {16'($urandom), 32'($urandom)}; dl_src = {16'($urandom), 32'($urandom)};
    dl_ethtype = 16'($urandom); dl_vlantag = 16'($urandom);
    arp_op = 8'($urandom); arp_ip_src = $urandom; arp_ip_dst = $urandom;
    ip_tos = 6'($urandom); ip_proto = 8'($urandom); ip_src = $urandom; ip_dst = $urandom;
  endtask

  task automatic rand_fields(input logic [15:0] eth);
    f_src_port = 8'($urandom); f_len = 16'($urandom);
    f_dl_dst = {16'($urandom), 32'($urandom)}; f_dl_src = {16'($urandom), 32'($urandom)};
    f_eth = eth; f_vlan = 16'($urandom);
    f_tos = 6'($urandom); f_proto = 8'($urandom); f_arp_op = 8'($urandom);
    f_l3src = $urandom; f_l3dst = $urandom;
  endtask

  task automatic drive_l3(input bit is_ip);
    if (is_ip) begin
      ip_tos = f_tos; ip_proto = f_proto; ip_src = f_l3src; ip_dst = f_l3dst; ip_tp_done = 1'b1;
    end else begin
      arp_op = f_arp_op; arp_ip_src = f_l3src; arp_ip_dst = f_l3dst; arp_done = 1'b1;
    end
  endtask

  // d: cycle after dl_done at which the L3 result arrives (0 = same cycle).
  // ack_dly: OUTPUT cycles before lu_ack; 0 means lu_ack is held high from dl_done on.
  task automatic run_pkt(input int d, input int ack_dly, input bit stray, input bit with_start);
    bit is_ip, is_arp, l3, tmo;
    int lat;
    logic [5:0]    e_tos;
    logic [7:0]    e_proto;
    logic [31:0]   e_s, e_d;
    logic [KW-1:0] e_key;
    is_ip  = (f_eth == 16'h0800);
    is_arp = (f_eth == 16'h0806);
    l3     = is_ip || is_arp;
    tmo    = l3 && (d >= T);
    if (!l3 || d == 0) lat = 1;
    else if (!tmo)     lat = d + 1;
    else               lat = T;
    e_tos = '0; e_proto = '0; e_s = '0; e_d = '0;
    if (l3 && !tmo) begin
      e_tos   = is_ip ? f_tos : 6'd0;
      e_proto = is_ip ? f_proto : f_arp_op;
      e_s     = f_l3src;
      e_d     = f_l3dst;
    end
    e_key = {f_src_port, f_dl_src, f_dl_dst, f_vlan, f_eth, e_tos, e_proto, e_s, e_d};

    noise();
    dl_start = with_start; dl_done = 1'b1;
    pkt_len = f_len; src_port = f_src_port; dl_dst = f_dl_dst; dl_src = f_dl_src;
    dl_ethtype = f_eth; dl_vlantag = f_vlan;
    lu_ack = (ack_dly == 0);
    if (l3 && d == 0) drive_l3(is_ip);
    for (int c = 1; c <= lat; c++) begin
      tick();
      noise();
      if (c < lat) begin
        check("req_early", 256'(lu_req), 256'(0));
        if (l3 && c == d) drive_l3(is_ip);
        if (stray && c == 1) begin
          if (is_ip) arp_done = 1'b1; else ip_tp_done = 1'b1;
          exp_drop++;
        end
      end
    end
    check("req_on_time", 256'(lu_req), 256'(1));
    check("key", 256'(lu_entry), 256'(e_key));
    check("pkt_len", 256'(lu_pkt_len), 256'(f_len));
    if (stray) begin
      dl_start = 1'b1;
      exp_drop++;
    end
    for (int a = 0; a < ack_dly; a++) begin
      tick();
      noise();
      check("req_hold", 256'(lu_req), 256'(1));
      check("key_hold", 256'(lu_entry), 256'(e_key));
      check("done_early", 256'(compose_done), 256'(0));
    end
    lu_ack = 1'b1;
    tick();
    noise();
    lu_ack = 1'b0;
    exp_compose++;
    if (tmo) exp_timeout++;
    check("compose_done", 256'(compose_done), 256'(1));
    check("req_drop", 256'(lu_req), 256'(0));
    check("compose_cnt", 256'(compose_cnt), 256'(exp_compose));
    check("timeout_cnt", 256'(timeout_cnt), 256'(exp_timeout));
    check("drop_cnt", 256'(drop_cnt), 256'(exp_drop));
    tick();
    check("done_pulse", 256'(compose_done), 256'(0));
  endtask

  initial begin
    int sel, d;
    aresetn = 1'b0;
    lu_ack  = 1'b0;
    noise();
    repeat (3) tick();
    aresetn = 1'b1;
    tick();
    check("rst_req", 256'(lu_req), 256'(0));
    check("rst_done", 256'(compose_done), 256'(0));
    check("rst_key", 256'(lu_entry), 256'(0));
    check("rst_cnts", 256'({compose_cnt, timeout_cnt, drop_cnt}), 256'(0));

    // Non-IP with lu_ack tied high.
    rand_fields(16'h88CC); f_src_port = 8'd3;
    run_pkt(0, 0, 1'b0, 1'b0);
    // IPv4 with late result and delayed ack.
    rand_fields(16'h0800);
    f_l3src = 32'h0A000001; f_l3dst = 32'h0A000002; f_proto = 8'd6; f_tos = 6'h2E;
    run_pkt(5, 4, 1'b0, 1'b1);
    // ARP result in the dl_done cycle.
    rand_fields(16'h0806); f_arp_op = 8'h02;
    run_pkt(0, 1, 1'b0, 1'b0);
    // Timeout, then the expected result in the expiry cycle.
    rand_fields(16'h0800);
    run_pkt(T + 2, 0, 1'b0, 1'b0);
    rand_fields(16'h0800);
    run_pkt(T - 1, 2, 1'b0, 1'b0);
    rand_fields(16'h0806);
    run_pkt(T, 1, 1'b0, 1'b0);

    // Stray L3 done in IDLE, then stray traffic around an IPv4 packet.
    noise();
    ip_tp_done = 1'b1;
    tick();
    noise();
    exp_drop++;
    check("idle_drop", 256'(drop_cnt), 256'(exp_drop));
    rand_fields(16'h0800);
    run_pkt(10, 2, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 2));
      if (sel == 0)      rand_fields(16'h0800);
      else if (sel == 1) rand_fields(16'h0806);
      else               rand_fields(16'h1000 + 16'($urandom_range(0, 16'h6FFF)));
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(T - 2, T + 3))
                                      : int'($urandom_range(0, 12));
      run_pkt(d, int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom));
    end

    // Asynchronous reset while a key is being offered.
    rand_fields(16'h1234);
    noise();
    dl_done = 1'b1; dl_ethtype = f_eth;
    tick();
    noise();
    check("pre_rst_req", 256'(lu_req), 256'(1));
    #2 aresetn = 1'b0;
    #1;
    exp_compose = 0; exp_timeout = 0; exp_drop = 0;
    check("async_rst_req", 256'(lu_req), 256'(0));
    check("async_rst_key", 256'(lu_entry), 256'(0));
    check("async_rst_cnts", 256'({compose_cnt, timeout_cnt, drop_cnt}), 256'(0));
    lu_ack = 1'b1;
    tick();
    aresetn = 1'b1;
    lu_ack  = 1'b0;
    tick();
    check("post_rst_done", 256'(compose_done), 256'(0));
    check("post_rst_req", 256'(lu_req), 256'(0));
    check("post_rst_cnt", 256'(compose_cnt), 256'(exp_compose));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
